note_engine: RTL and testbench

//  Gameplay engine driven by the top-level game FSM's 3-bit state; produces that FSM's stop_tag.

---
 rtl/game_pkg.sv | 28 ++
 rtl/lfsr8.sv | 19 +
 rtl/note_engine.sv | 142 ++++++++++++++
 tb/tb_note_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared encodings, widths and helpers for the note gameplay engine.
// Covers the game FSM state codes, the engine states, the speed period table and saturating counts.
package game_pkg;
    localparam int POS_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_STOP  = 3'd2,
        ST_SCORE = 3'd3,
        ST_SPEED = 3'd4,
        ST_MISS  = 3'd5
    } game_state_t;

    typedef enum logic [1:0] {E_WAIT, E_FALL, E_DONE} eng_state_t;

    // Ticks per row step: level 0..3 -> 8,4,2,1
    function automatic logic [3:0] speed_period(input logic [1:0] lvl);
        return 4'd8 >> lvl;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction
endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4), shifting left with feedback into bit 0.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_seed,
    input  logic       advance,
    output logic [7:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= SEED;
        else if (load_seed)
            q <= SEED;
        else if (advance)
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
endmodule

// File: rtl/note_engine.sv
// note_engine: falling-note gameplay engine slaved to the game FSM state.
// Picks speed in SPEED, runs one round of notes in PLAY, scores hits/misses and pulses stop_tag.
module note_engine
    import game_pkg::*;
#(
    parameter int         NOTES_PER_ROUND = 16,
    parameter int         HIT_POS         = 7,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       state,
    input  logic             tick,
    input  logic             btn_up,
    input  logic [3:0]       btn_hit,
    output logic             stop_tag,
    output logic [1:0]       speed_level,
    output logic             note_active,
    output logic [1:0]       note_lane,
    output logic [POS_W-1:0] note_pos,
    output logic [CNT_W-1:0] score_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam logic [POS_W-1:0] HIT   = POS_W'(HIT_POS);
    localparam logic [7:0]       NOTES = 8'(NOTES_PER_ROUND);

    eng_state_t       e, n_e;
    logic [7:0]       lfsr_q, done, n_done;
    logic [2:0]       step, n_step;
    logic [1:0]       n_speed, n_lane, miss_inc;
    logic [POS_W-1:0] n_pos;
    logic [CNT_W-1:0] n_score, n_miss;
    logic             n_active, n_stop, load, adv, spawn, retire, hit, stp;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_seed(load),
        .advance  (adv),
        .q        (lfsr_q)
    );

    always_comb begin
        n_e      = e;
        n_done   = done;
        n_step   = step;
        n_speed  = speed_level;
        n_lane   = note_lane;
        n_pos    = note_pos;
        n_score  = score_cnt;
        n_miss   = miss_cnt;
        n_active = note_active;
        n_stop   = 1'b0;
        load     = 1'b0;
        adv      = 1'b0;
        spawn    = 1'b0;
        retire   = 1'b0;
        hit      = 1'b0;
        stp      = 1'b0;
        miss_inc = 2'd0;
        // Undefined codes fall into the idle branch
        if (!(state inside {ST_PLAY, ST_STOP, ST_SCORE, ST_SPEED, ST_MISS})) begin
            n_score  = '0;
            n_miss   = '0;
            n_done   = '0;
            n_step   = '0;
            n_active = 1'b0;
            load     = 1'b1;
            n_e      = E_WAIT;
        end else if (state != ST_PLAY) begin
            n_active = 1'b0;
            n_e      = E_WAIT;
            if (state == ST_SPEED && btn_up)
                n_speed = speed_level + 2'd1;
        end else if (e == E_WAIT) begin
            spawn = 1'b1;
        end else if (e == E_FALL) begin
            hit = |btn_hit && note_pos == HIT && btn_hit[note_lane];
            stp = tick && {1'b0, step} == speed_period(speed_level) - 4'd1;
            if (hit) begin
                n_score = sat_add(score_cnt, 2'd1);
                retire  = 1'b1;
            end else begin
                miss_inc = 2'(|btn_hit) + 2'(stp && note_pos >= HIT);
                n_miss   = sat_add(miss_cnt, miss_inc);
                if (stp) begin
                    n_step = '0;
                    if (note_pos < HIT)
                        n_pos = note_pos + 1'b1;
                    else
                        retire = 1'b1;
                end else if (tick) begin
                    n_step = step + 3'd1;
                end
            end
            if (retire) begin
                n_done = done + 8'd1;
                if (n_done == NOTES) begin
                    n_active = 1'b0;
                    n_stop   = 1'b1;
                    n_e      = E_DONE;
                end else begin
                    spawn = 1'b1;
                end
            end
        end
        if (spawn) begin
            n_pos    = '0;
            n_lane   = lfsr_q[1:0];
            n_active = 1'b1;
            n_step   = '0;
            adv      = 1'b1;
            n_e      = E_FALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e           <= E_WAIT;
            done        <= '0;
            step        <= '0;
            stop_tag    <= 1'b0;
            speed_level <= '0;
            note_active <= 1'b0;
            note_lane   <= '0;
            note_pos    <= '0;
            score_cnt   <= '0;
            miss_cnt    <= '0;
        end else begin
            e           <= n_e;
            done        <= n_done;
            step        <= n_step;
            stop_tag    <= n_stop;
            speed_level <= n_speed;
            note_active <= n_active;
            note_lane   <= n_lane;
            note_pos    <= n_pos;
            score_cnt   <= n_score;
            miss_cnt    <= n_miss;
        end
    end
endmodule

// File: tb/tb_note_engine.sv
// tb_note_engine: directed self-checking bench for note_engine.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_note_engine;
    logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, btn_up = 1'b0;
    logic [2:0] state = 3'd0;
    logic [3:0] btn_hit = 4'd0;
    logic       stop_tag, note_active;
    logic [1:0] speed_level, note_lane;
    logic [2:0] note_pos;
    logic [7:0] score_cnt, miss_cnt;
    int tests = 0, fails = 0, stop_cnt = 0;

    note_engine dut (
        .clk(clk), .rst_n(rst_n), .state(state), .tick(tick), .btn_up(btn_up),
        .btn_hit(btn_hit), .stop_tag(stop_tag), .speed_level(speed_level),
        .note_active(note_active), .note_lane(note_lane), .note_pos(note_pos),
        .score_cnt(score_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (stop_tag) stop_cnt++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic up_pulse();
        btn_up = 1'b1;
        cyc();
        btn_up = 1'b0;
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    initial begin
        logic [7:0] lf;
        logic [1:0] lane;
        int s0, n;
        #3;
        chk("rst_stop", stop_tag, 0);
        chk("rst_speed", speed_level, 0);
        chk("rst_active", note_active, 0);
        chk("rst_lane", note_lane, 0);
        chk("rst_pos", note_pos, 0);
        chk("rst_score", score_cnt, 0);
        chk("rst_miss", miss_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // speed selection: 5 pulses from 0 -> 1, ignored in play
        state = 3'd4;
        up_pulse();
        chk("spd_first", speed_level, 1);
        repeat (4) up_pulse();
        cyc();
        chk("spd_five", speed_level, 1);
        state = 3'd1;
        cyc();
        up_pulse();
        chk("spd_in_play", speed_level, 1);
        chk("play_active", note_active, 1);
        chk("play_lane", note_lane, 1);

        // asynchronous reset mid-play, no edge in between
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_active", note_active, 0);
        chk("arst_lane", note_lane, 0);
        chk("arst_speed", speed_level, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        state = 3'd0;
        cyc();

        // level 3, every note hit at the bottom row
        state = 3'd4;
        repeat (3) up_pulse();
        chk("t3_speed", speed_level, 3);
        state = 3'd0;
        cyc();
        state = 3'd1;
        tick  = 1'b1;
        lf    = 8'hA5;
        s0    = stop_cnt;
        cyc();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_lane%0d", i), note_lane, lf[1:0]);
            lane = lf[1:0];
            lf   = lfsr_next(lf);
            n    = 0;
            while (note_pos != 3'd7 && n < 20) begin
                cyc();
                n++;
            end
            chk($sformatf("t3_reach%0d", i), note_pos, 7);
            btn_hit = 4'b0001 << lane;
            cyc();
            btn_hit = 4'd0;
        end
        chk("t3_stop", stop_tag, 1);
        chk("t3_active", note_active, 0);
        chk("t3_score", score_cnt, 16);
        chk("t3_miss", miss_cnt, 0);
        cyc();
        chk("t3_stop_clr", stop_tag, 0);
        repeat (3) cyc();
        chk("t3_stop_once", stop_cnt - s0, 1);
        chk("t3_score_hold", score_cnt, 16);
        tick = 1'b0;

        // level 0 (3 wraps to 0), no presses: every note missed
        state = 3'd4;
        up_pulse();
        chk("t4_wrap", speed_level, 0);
        state = 3'd0;
        cyc();
        state = 3'd1;
        tick  = 1'b1;
        s0    = stop_cnt;
        cyc();
        repeat (55) cyc();
        chk("t4_pos55", note_pos, 6);
        cyc();
        chk("t4_pos56", note_pos, 7);
        repeat (7) cyc();
        chk("t4_pos63", note_pos, 7);
        chk("t4_miss63", miss_cnt, 0);
        cyc();
        chk("t4_miss64", miss_cnt, 1);
        chk("t4_respawn", note_pos, 0);
        chk("t4_active", note_active, 1);
        repeat (959) cyc();
        chk("t4_pre_stop", stop_tag, 0);
        cyc();
        chk("t4_stop", stop_tag, 1);
        chk("t4_miss", miss_cnt, 16);
        chk("t4_score", score_cnt, 0);
        chk("t4_inactive", note_active, 0);
        repeat (3) cyc();
        chk("t4_stop_once", stop_cnt - s0, 1);
        tick = 1'b0;

        // bad presses and hit-over-step priority, cleared via undefined state 7
        state = 3'd4;
        repeat (3) up_pulse();
        state = 3'd7;
        cyc();
        chk("t5_clr_score", score_cnt, 0);
        chk("t5_clr_miss", miss_cnt, 0);
        state = 3'd1;
        cyc();
        chk("t5_lane", note_lane, 1);
        tick = 1'b1;
        repeat (3) cyc();
        tick = 1'b0;
        chk("t5_pos3", note_pos, 3);
        btn_hit = 4'b1111;
        cyc();
        btn_hit = 4'd0;
        chk("t5_multi_miss", miss_cnt, 1);
        chk("t5_multi_pos", note_pos, 3);
        chk("t5_multi_score", score_cnt, 0);
        tick = 1'b1;
        repeat (4) cyc();
        tick = 1'b0;
        chk("t5_pos7", note_pos, 7);
        btn_hit = 4'b0001;
        cyc();
        btn_hit = 4'd0;
        chk("t5_wrong_miss", miss_cnt, 2);
        chk("t5_wrong_pos", note_pos, 7);
        chk("t5_wrong_active", note_active, 1);
        btn_hit = 4'b0010;
        tick    = 1'b1;
        cyc();
        btn_hit = 4'd0;
        tick    = 1'b0;
        chk("t5_hit_score", score_cnt, 1);
        chk("t5_hit_miss", miss_cnt, 2);
        chk("t5_next_pos", note_pos, 0);
        chk("t5_next_lane", note_lane, 2);

        // leave play mid-round, re-enter, then idle clears and reseeds
        state = 3'd2;
        cyc();
        chk("t6_stop_active", note_active, 0);
        chk("t6_stop_score", score_cnt, 1);
        chk("t6_stop_miss", miss_cnt, 2);
        state = 3'd1;
        cyc();
        chk("t6_reenter_active", note_active, 1);
        chk("t6_reenter_score", score_cnt, 1);
        chk("t6_reenter_lane", note_lane, 1);
        state = 3'd3;
        cyc();
        state = 3'd0;
        cyc();
        chk("t6_idle_score", score_cnt, 0);
        chk("t6_idle_miss", miss_cnt, 0);
        chk("t6_idle_active", note_active, 0);
        state = 3'd1;
        cyc();
        chk("t6_seed_lane", note_lane, 1);
        chk("t6_seed_active", note_active, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
